// File: rtl/sram_pkg.sv
// Shared constants and types for the board SRAM model (256K x 16, two byte lanes).
package sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_DEPTH  = 2 ** SRAM_ADDR_W;
    localparam int SRAM_LANE_W = 8;

    typedef logic [SRAM_DATA_W-1:0] sram_word_t;
    typedef logic [SRAM_LANE_W-1:0] sram_byte_t;

endpackage

// File: rtl/sram_byte_lane.sv
// One byte lane of the SRAM model: an 8-bit storage slice with its own write
// enable, plus the read data and drive enable for this lane's half of the bus.
module sram_byte_lane
    import sram_pkg::*;
#(
    parameter int DEPTH = SRAM_DEPTH,
    parameter int IDX_W = SRAM_ADDR_W
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             in_range_i,
    input  logic             we_i,
    input  sram_byte_t       wdata_i,
    input  logic             rd_i,
    output sram_byte_t       rdata_o,
    output logic             drive_o
);

    sram_byte_t mem_q [DEPTH];

    // Commit this lane's byte at the clock edge; the top has already folded
    // reset, chip/write enables, range and lane select into we_i.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Asynchronous read path: follows idx_i immediately; out-of-range words read as zero.
    always_comb begin
        rdata_o = '0;
        if (in_range_i) begin
            rdata_o = mem_q[idx_i];
        end
        drive_o = rd_i;
    end

endmodule

// File: rtl/sram.sv
// Behavioural model of the external asynchronous SRAM on the board pins.
// Writes land on the rising clock edge; reads are combinational and tri-stated
// per byte lane. A registered reset flag keeps the bus released while the
// controller is held in reset.
module sram
    import sram_pkg::*;
#(
    parameter int    ADDR_W    = SRAM_ADDR_W,
    parameter int    DATA_W    = SRAM_DATA_W,   // two byte lanes: must stay 16
    parameter int    DEPTH     = 2 ** ADDR_W,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N
);

    localparam int                LANE_W  = SRAM_LANE_W;
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic             rst_seen_q;
    logic             rst_seen_d;
    logic             in_range;
    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] idx;
    sram_byte_t       hi_rdata;
    sram_byte_t       lo_rdata;
    logic             hi_drive;
    logic             lo_drive;

    assign rst_seen_d = ~rst;

    // Remember whether the most recent edge sampled reset asserted; the bus
    // stays released until an edge samples rst high again.
    always_ff @(posedge clk) begin
        rst_seen_q <= rst_seen_d;
    end

    // Enable decode and range check. WE_N low always wins over OE_N so the
    // model never fights the controller while it is driving write data.
    always_comb begin
        in_range = ({1'b0, SRAM_ADDR} < DEPTH_V);
        idx      = SRAM_ADDR[IDX_W-1:0];
        wr_en    = rst & ~SRAM_CE_N & ~SRAM_WE_N & in_range;
        rd_en    = rst & ~rst_seen_q & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
    end

    sram_byte_lane #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_lane_hi (
        .clk_i      (clk),
        .idx_i      (idx),
        .in_range_i (in_range),
        .we_i       (wr_en & ~SRAM_UB_N),
        .wdata_i    (SRAM_DQ[DATA_W-1:LANE_W]),
        .rd_i       (rd_en & ~SRAM_UB_N),
        .rdata_o    (hi_rdata),
        .drive_o    (hi_drive)
    );

    sram_byte_lane #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_lane_lo (
        .clk_i      (clk),
        .idx_i      (idx),
        .in_range_i (in_range),
        .we_i       (wr_en & ~SRAM_LB_N),
        .wdata_i    (SRAM_DQ[LANE_W-1:0]),
        .rd_i       (rd_en & ~SRAM_LB_N),
        .rdata_o    (lo_rdata),
        .drive_o    (lo_drive)
    );

    // Pad drivers: each lane releases its half of the bus independently.
    assign SRAM_DQ[DATA_W-1:LANE_W] = hi_drive ? hi_rdata : {LANE_W{1'bz}};
    assign SRAM_DQ[LANE_W-1:0]      = lo_drive ? lo_rdata : {LANE_W{1'bz}};

endmodule

// File: tb/tb_sram.sv
// Bench for the SRAM model. Two identical instances sit on a pulled-up bus and a
// pulled-down bus so that a released lane is visible as FF on one and 00 on the other.
module tb_sram;

    localparam int ADDR_W = 18;
    localparam int DEPTH  = 1024;

    typedef struct packed {
        logic              rst;
        logic              ce_n;
        logic              oe_n;
        logic              we_n;
        logic              ub_n;
        logic              lb_n;
        logic              drv;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wd;
        logic [1:0]        chkm;   // lanes to check {hi, lo}
        logic [1:0]        expz;   // lanes expected released {hi, lo}
        logic [15:0]       exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst, ce_n, oe_n, we_n, ub_n, lb_n, drv;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wd;
    tri1  [15:0]       dq_u;
    tri0  [15:0]       dq_d;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: byte arrays plus "known" flags and the reset-seen state
    logic [7:0] m_hi [DEPTH];
    logic [7:0] m_lo [DEPTH];
    bit         k_hi [DEPTH];
    bit         k_lo [DEPTH];
    bit         m_rst_seen = 1'b1;

    vec_t tbl [30];

    always #5 clk = ~clk;

    assign dq_u = drv ? wd : 16'hzzzz;
    assign dq_d = drv ? wd : 16'hzzzz;

    sram #(.ADDR_W(ADDR_W), .DATA_W(16), .DEPTH(DEPTH), .INIT_FILE("")) dut_u (
        .clk(clk), .rst(rst), .SRAM_DQ(dq_u), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    sram #(.ADDR_W(ADDR_W), .DATA_W(16), .DEPTH(DEPTH), .INIT_FILE("")) dut_d (
        .clk(clk), .rst(rst), .SRAM_DQ(dq_d), .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    function automatic vec_t mk(input logic r, input logic ce, input logic oe, input logic we,
                                input logic ub, input logic lb, input logic [ADDR_W-1:0] a,
                                input logic [15:0] d, input logic [1:0] z, input logic [15:0] e);
        vec_t v;
        v.rst = r; v.ce_n = ce; v.oe_n = oe; v.we_n = we; v.ub_n = ub; v.lb_n = lb;
        v.drv = ~we; v.addr = a; v.wd = d; v.chkm = 2'b11; v.expz = z; v.exp = e;
        return v;
    endfunction

    task automatic check_bus(input string nm, input logic [1:0] chkm, input logic [1:0] expz,
                             input logic [15:0] exp);
        logic [15:0] m, z, want_u, want_d;
        logic        ok;
        if (chkm == 2'b00) return;
        m      = {{8{chkm[1]}}, {8{chkm[0]}}};
        z      = {{8{expz[1]}}, {8{expz[0]}}};
        want_u = z | (~z & exp);
        want_d = ~z & exp;
        ok     = ((dq_u & m) === (want_u & m)) && ((dq_d & m) === (want_d & m));
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: bus pullup=%h pulldown=%h, required data %h with released lanes %b (lanes checked %b)",
                     nm, dq_u, dq_d, exp, expz, chkm);
        end
    endtask

    // What the bus should show for these pins given the model's current state.
    task automatic model_expect(input vec_t v, output logic [1:0] chkm, output logic [1:0] expz,
                                output logic [15:0] exp);
        bit rd, inr;
        int a;
        rd   = v.rst && !m_rst_seen && !v.ce_n && !v.oe_n && v.we_n;
        inr  = (v.addr < DEPTH);
        a    = inr ? int'(v.addr) : 0;
        chkm = 2'b11; expz = 2'b11; exp = 16'h0000;
        if (rd) begin
            if (!v.ub_n) begin
                expz[1] = 1'b0;
                if (inr) begin
                    if (k_hi[a]) exp[15:8] = m_hi[a];
                    else chkm[1] = 1'b0;
                end
            end
            if (!v.lb_n) begin
                expz[0] = 1'b0;
                if (inr) begin
                    if (k_lo[a]) exp[7:0] = m_lo[a];
                    else chkm[0] = 1'b0;
                end
            end
        end
    endtask

    // Effect of the coming clock edge on the model.
    task automatic model_commit(input vec_t v);
        int a;
        if (v.rst && !v.ce_n && !v.we_n && (v.addr < DEPTH)) begin
            a = int'(v.addr);
            if (!v.ub_n) begin m_hi[a] = v.wd[15:8]; k_hi[a] = v.drv; end
            if (!v.lb_n) begin m_lo[a] = v.wd[7:0];  k_lo[a] = v.drv; end
        end
        m_rst_seen = !v.rst;
    endtask

    // One bus cycle: apply pins with the bench released, check, then drive write data.
    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        rst = v.rst; ce_n = v.ce_n; oe_n = v.oe_n; we_n = v.we_n;
        ub_n = v.ub_n; lb_n = v.lb_n; addr = v.addr; wd = v.wd; drv = 1'b0;
        #1;
        check_bus(nm, v.chkm, v.expz, v.exp);
        drv = v.drv;
        #1;
        model_commit(v);
    endtask

    initial begin
        vec_t        v;
        logic [1:0]  cm, ez;
        logic [15:0] ex;

        rst = 1'b0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        addr = '0; wd = '0; drv = 1'b0;

        //            rst ce oe we ub lb addr  wdata     Z      expected
        tbl[0]  = mk(0, 1, 1, 1, 0, 0, 0,    16'h0000, 2'b11, 16'h0000);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,    16'h1234, 2'b11, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,    16'hDEAD, 2'b11, 16'h0000);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0,    16'h0000, 2'b11, 16'h0000);
        tbl[4]  = mk(1, 0, 0, 1, 0, 0, 0,    16'h0000, 2'b11, 16'h0000);
        tbl[5]  = mk(1, 0, 0, 1, 0, 0, 0,    16'h0000, 2'b00, 16'h1234);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0,    16'd1024, 2'b11, 16'h0000);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1,    16'd2048, 2'b11, 16'h0000);
        tbl[8]  = mk(1, 0, 0, 1, 0, 0, 0,    16'h0000, 2'b00, 16'h0400);
        tbl[9]  = mk(1, 0, 0, 1, 0, 0, 1,    16'h0000, 2'b00, 16'h0800);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 5,    16'hAABB, 2'b11, 16'h0000);
        tbl[11] = mk(1, 0, 0, 0, 1, 0, 5,    16'h1122, 2'b11, 16'h0000);
        tbl[12] = mk(1, 0, 0, 1, 0, 0, 5,    16'h0000, 2'b00, 16'hAA22);
        tbl[13] = mk(1, 0, 0, 1, 0, 1, 5,    16'h0000, 2'b01, 16'hAA00);
        tbl[14] = mk(1, 0, 0, 1, 1, 0, 5,    16'h0000, 2'b10, 16'h0022);
        tbl[15] = mk(1, 0, 1, 1, 0, 0, 5,    16'h0000, 2'b11, 16'h0000);
        tbl[16] = mk(1, 1, 0, 1, 0, 0, 5,    16'h0000, 2'b11, 16'h0000);
        tbl[17] = mk(1, 1, 0, 0, 0, 0, 5,    16'hDEAD, 2'b11, 16'h0000);
        tbl[18] = mk(1, 0, 0, 1, 0, 0, 5,    16'h0000, 2'b00, 16'hAA22);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 976,  16'h1111, 2'b11, 16'h0000);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 2000, 16'hBEEF, 2'b11, 16'h0000);
        tbl[21] = mk(1, 0, 0, 1, 0, 0, 2000, 16'h0000, 2'b00, 16'h0000);
        tbl[22] = mk(1, 0, 0, 1, 1, 0, 2000, 16'h0000, 2'b10, 16'h0000);
        tbl[23] = mk(1, 0, 0, 1, 0, 0, 976,  16'h0000, 2'b00, 16'h1111);
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 1023, 16'h5A5A, 2'b11, 16'h0000);
        tbl[25] = mk(1, 0, 0, 1, 0, 0, 1023, 16'h0000, 2'b00, 16'h5A5A);
        tbl[26] = mk(1, 0, 0, 1, 0, 0, 1024, 16'h0000, 2'b00, 16'h0000);
        tbl[27] = mk(0, 0, 0, 1, 0, 0, 0,    16'h0000, 2'b11, 16'h0000);
        tbl[28] = mk(1, 0, 0, 1, 0, 0, 0,    16'h0000, 2'b11, 16'h0000);
        tbl[29] = mk(1, 0, 0, 1, 0, 0, 0,    16'h0000, 2'b00, 16'h0400);

        for (int i = 0; i < 30; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Address change mid-cycle, then a write to the word being read.
        @(negedge clk);
        rst = 1'b1; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
        drv = 1'b0; addr = 0;
        #1 check_bus("addr_mid_0", 2'b11, 2'b00, 16'h0400);
        addr = 1;
        #1 check_bus("addr_mid_1_old", 2'b11, 2'b00, 16'h0800);
        we_n = 1'b0; wd = 16'h0BEE;
        #1 check_bus("we_overrides_oe", 2'b11, 2'b11, 16'h0000);
        drv = 1'b1;
        model_commit(mk(1, 0, 0, 0, 0, 0, 1, 16'h0BEE, 2'b11, 16'h0000));
        @(posedge clk);
        #1;
        we_n = 1'b1; drv = 1'b0;
        #1 check_bus("read_after_edge", 2'b11, 2'b00, 16'h0BEE);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v.rst  = ($urandom_range(0, 19) != 0);
            v.ce_n = ($urandom_range(0, 5) == 0);
            v.we_n = ($urandom_range(0, 2) != 0);
            v.oe_n = ($urandom_range(0, 4) == 0);
            v.ub_n = ($urandom_range(0, 3) == 0);
            v.lb_n = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                6:       v.addr = ADDR_W'(1016 + $urandom_range(0, 15));
                7:       v.addr = ADDR_W'(2000);
                8:       v.addr = ADDR_W'($urandom);
                9:       v.addr = ADDR_W'(976);
                default: v.addr = ADDR_W'($urandom_range(0, 15));
            endcase
            v.wd  = 16'($urandom);
            v.drv = ~v.we_n;
            model_expect(v, cm, ez, ex);
            v.chkm = cm; v.expz = ez; v.exp = ex;
            step(v, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
